// File: rtl/match_report_queue_pkg.sv
// Shared definitions for the match report queue: FSM encoding and default geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package match_report_queue_pkg;

  // Default geometry for a 640x480 image with an 8-deep per-frame buffer.
  localparam int MRQ_X_WIDTH = 10;
  localparam int MRQ_Y_WIDTH = 9;
  localparam int MRQ_DEPTH   = 8;
  localparam int MRQ_CNT_W   = 12;

  // The encoding is visible on the debug state port, so the values are pinned.
  typedef enum logic [1:0] {
    MRQ_IDLE    = 2'd0,
    MRQ_COLLECT = 2'd1,
    MRQ_DRAIN   = 2'd2,
    MRQ_END     = 2'd3
  } mrq_state_t;

endpackage

// File: rtl/match_report_queue_coord_fifo.sv
// Synchronous FIFO for packed {x,y} coordinates with a registered head output.
// Latency: a word written at edge N appears on o_rd_vld/o_rd_dat after edge N+1.
// Backpressure: o_wr_rdy drops when full unless a read happens the same cycle; head holds while !i_rd_rdy.
//
// Ports: i_clock/i_reset (sync, active-high), i_flush empties the FIFO,
//        i_wr_vld/i_wr_dat/o_wr_rdy write side, o_rd_vld/o_rd_dat/i_rd_rdy read side,
//        o_count = entries held, including the one shown on the head register.
module match_report_queue_coord_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_wr_vld,
  input  logic [W-1:0]             i_wr_dat,
  output logic                     o_wr_rdy,
  output logic                     o_rd_vld,
  output logic [W-1:0]             o_rd_dat,
  input  logic                     i_rd_rdy,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rd_vld;
  logic [W-1:0]  r_rd_dat;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_idx;
  logic [AW:0]   w_avail;

  assign w_pop    = r_rd_vld && i_rd_rdy;
  assign o_wr_rdy = (r_count != FULL) || w_pop;
  assign w_push   = i_wr_vld && o_wr_rdy && !i_flush;

  // The head register is reloaded every cycle from the entry that will be at the
  // front after this edge. Only entries already counted before the edge qualify,
  // which gives the one-cycle write-to-head latency and lets back-to-back reads stream.
  assign w_rd_idx = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_avail  = r_count - (AW+1)'(w_pop);

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rd_vld <= 1'b0;
      r_rd_dat <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_rd_vld <= (w_avail != '0);
      r_rd_dat <= r_mem[w_rd_idx];
    end
  end

  assign o_rd_vld = r_rd_vld;
  assign o_rd_dat = r_rd_dat;
  assign o_count  = r_count;

endmodule

// File: rtl/match_report_queue.sv
// Collects every template-match coordinate of a frame and hands them out, closed by an all-ones end record.
// Latency: a match accepted at edge N is offered on o_out_valid after edge N+1 when the queue was empty.
// Backpressure: records hold while !i_out_ready; matches arriving with the queue full are dropped and flagged.
//
// Ports: i_clock/i_reset (sync, active-high); i_frame_start/i_frame_end frame pulses;
//        i_first_only keep-first mode (latched at reset/frame start); i_match_valid/x/y match strobe;
//        o_out_valid/i_out_ready/o_out_x/o_out_y/o_out_last record stream;
//        o_match_count, o_overflow per-frame status; o_frame_done end-record accepted; o_state debug.
module match_report_queue
  import match_report_queue_pkg::*;
#(
  parameter int X_WIDTH = MRQ_X_WIDTH,
  parameter int Y_WIDTH = MRQ_Y_WIDTH,
  parameter int DEPTH   = MRQ_DEPTH,
  parameter int CNT_W   = MRQ_CNT_W
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_frame_start,
  input  logic               i_frame_end,
  input  logic               i_first_only,
  input  logic               i_match_valid,
  input  logic [X_WIDTH-1:0] i_match_x,
  input  logic [Y_WIDTH-1:0] i_match_y,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [X_WIDTH-1:0] o_out_x,
  output logic [Y_WIDTH-1:0] o_out_y,
  output logic               o_out_last,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_overflow,
  output logic               o_frame_done,
  output logic [1:0]         o_state
);

  localparam int W  = X_WIDTH + Y_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mrq_state_t       r_state;
  logic [CNT_W-1:0] r_match_count;
  logic             r_overflow;
  logic             r_frame_done;
  logic             r_first_only;
  logic             r_got_first;

  logic             w_in_run;
  logic             w_match;
  logic             w_store;
  logic             w_fifo_wr_rdy;
  logic             w_fifo_rd_vld;
  logic [W-1:0]     w_fifo_rd_dat;
  logic [AW:0]      w_fifo_count;
  logic             w_head_vld;

  assign w_in_run = (r_state == MRQ_COLLECT) || (r_state == MRQ_DRAIN);
  // A frame_start in the same cycle wins over the match: the old frame is being discarded.
  assign w_match  = i_match_valid && (r_state == MRQ_COLLECT) && !i_frame_start;
  // In first-only mode, once one match is queued the rest are only counted.
  assign w_store  = w_match && !(r_first_only && r_got_first);

  match_report_queue_coord_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_coord_fifo (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_flush  (i_frame_start),
    .i_wr_vld (w_store),
    .i_wr_dat ({i_match_x, i_match_y}),
    .o_wr_rdy (w_fifo_wr_rdy),
    .o_rd_vld (w_fifo_rd_vld),
    .o_rd_dat (w_fifo_rd_dat),
    .i_rd_rdy (i_out_ready && w_in_run),
    .o_count  (w_fifo_count)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= MRQ_IDLE;
      r_match_count <= '0;
      r_overflow    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_first_only  <= i_first_only;
      r_got_first   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (i_frame_start) begin
        // New frame or abort: status restarts and the mode is re-sampled.
        r_state       <= MRQ_COLLECT;
        r_match_count <= '0;
        r_overflow    <= 1'b0;
        r_first_only  <= i_first_only;
        r_got_first   <= 1'b0;
      end else begin
        if (w_match && (r_match_count != CNT_MAX)) r_match_count <= r_match_count + 1'b1;
        if (w_store && !w_fifo_wr_rdy)             r_overflow    <= 1'b1;
        if (w_store && w_fifo_wr_rdy)              r_got_first   <= 1'b1;
        case (r_state)
          MRQ_COLLECT: if (i_frame_end) r_state <= MRQ_DRAIN;
          MRQ_DRAIN:   if (w_fifo_count == '0) r_state <= MRQ_END;
          MRQ_END: begin
            if (i_out_ready) begin
              r_state      <= MRQ_IDLE;
              r_frame_done <= 1'b1;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  // Outputs are selected purely from registered state: the FIFO head while a frame
  // is running, the all-ones end record in END, all-ones otherwise.
  assign w_head_vld    = w_in_run && w_fifo_rd_vld;
  assign o_out_valid   = (r_state == MRQ_END) || w_head_vld;
  assign o_out_last    = (r_state == MRQ_END);
  assign o_out_x       = w_head_vld ? w_fifo_rd_dat[W-1:Y_WIDTH] : '1;
  assign o_out_y       = w_head_vld ? w_fifo_rd_dat[Y_WIDTH-1:0] : '1;
  assign o_match_count = r_match_count;
  assign o_overflow    = r_overflow;
  assign o_frame_done  = r_frame_done;
  assign o_state       = r_state;

endmodule
